// File: rtl/ram_refresh_seq.sv
// CAS-before-RAS DRAM refresh sequencer fed by the refresh/QoS timer.
// Define REF_MISS_EN to build the 4-bit saturating missed-refresh counter behind RefMiss.
module ram_refresh_seq #(
    parameter int unsigned TCASPRE = 1,
    parameter int unsigned TRAS    = 3,
    parameter int unsigned TRP     = 2
) (
    input  logic CLK,
    input  logic nPOR,
    input  logic RefReq,
    input  logic RefUrg,
    input  logic nAS,
    input  logic RAMCS,
    output logic nRAS,
    output logic nCAS,
    output logic RAMHold,
    output logic RefAck,
    output logic RefMiss
);
    typedef enum logic [2:0] {StIdle, StPend, StCasLo, StRasLo, StPrech} stateT;

    localparam logic [2:0] CasPreLd = 3'(TCASPRE - 1);
    localparam logic [2:0] RasLd    = 3'(TRAS - 1);
    localparam logic [2:0] RpLd     = 3'(TRP - 1);

    stateT      state;
    logic [2:0] cnt;
    logic       refReqQ;
    logic       pending;
    logic       reArm;
    logic       busIdle;
    logic       refRise;
    logic       enterRas;

    assign busIdle  = nAS || !RAMCS;
    assign refRise  = RefReq && !refReqQ;
    assign enterRas = (state == StCasLo) && (cnt == 3'd0);

    always_ff @(posedge CLK or negedge nPOR) begin
        if (!nPOR) begin
            state   <= StIdle;
            cnt     <= 3'd0;
            nRAS    <= 1'b1;
            nCAS    <= 1'b1;
            RAMHold <= 1'b0;
            RefAck  <= 1'b0;
            pending <= 1'b0;
            reArm   <= 1'b0;
            refReqQ <= 1'b1;
        end else begin
            refReqQ <= RefReq;
            RefAck  <= 1'b0;

            // A request arriving during CASLO must survive the clear on RASLO entry.
            if (enterRas) begin
                pending <= refRise || reArm;
                reArm   <= 1'b0;
            end else if (refRise) begin
                pending <= 1'b1;
                if (state == StCasLo) reArm <= 1'b1;
            end

            case (state)
                StIdle: begin
                    if (pending) state <= StPend;
                end
                StPend: begin
                    RAMHold <= RefUrg;
                    if (busIdle) begin
                        state   <= StCasLo;
                        cnt     <= CasPreLd;
                        nCAS    <= 1'b0;
                        RAMHold <= 1'b1;
                    end
                end
                StCasLo: begin
                    if (cnt == 3'd0) begin
                        state <= StRasLo;
                        cnt   <= RasLd;
                        nRAS  <= 1'b0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                StRasLo: begin
                    if (cnt == 3'd0) begin
                        state <= StPrech;
                        cnt   <= RpLd;
                        nRAS  <= 1'b1;
                        nCAS  <= 1'b1;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                StPrech: begin
                    if (cnt == 3'd0) begin
                        state   <= StIdle;
                        RAMHold <= 1'b0;
                        RefAck  <= 1'b1;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef REF_MISS_EN
    logic [3:0] missCnt;
    logic       missEvent;

    assign missEvent = refRise && pending && ((state == StIdle) || (state == StPend));

    always_ff @(posedge CLK or negedge nPOR) begin
        if (!nPOR) begin
            missCnt <= 4'd0;
        end else if (missEvent && (missCnt != 4'hF)) begin
            missCnt <= missCnt + 4'd1;
        end
    end

    assign RefMiss = (missCnt != 4'd0);
`else
    assign RefMiss = 1'b0;
`endif

endmodule

// File: doc/ram_refresh_seq.md
# ram_refresh_seq

CAS-before-RAS DRAM refresh sequencer. Sits directly downstream of the refresh/QoS timer and consumes its registered `RefReq`/`RefUrg` outputs. Each refresh period it issues exactly one CBR refresh cycle on `nRAS`/`nCAS`:

- **Opportunistically** when the CPU is not accessing RAM.
- **Forcibly** once urgency is flagged, by asserting `RAMHold` to the RAM controller.

It owns the refresh strobes; the RAM controller ORs them with its own access strobes.

## Interface
Parameters:
- `TCASPRE`, default 1: CLK cycles `nCAS` is low before `nRAS` falls (1..3).
- `TRAS`, default 3: CLK cycles `nRAS` is held low (1..7).
- `TRP`, default 2: CLK cycles of precharge after the strobes rise (1..7).

Ports:
- `CLK` in 1: FSB clock; all state changes on the rising edge.
- `nPOR` in 1: asynchronous, active-low reset.
- `RefReq` in 1: refresh-period request, level; synchronous to `CLK`.
- `RefUrg` in 1: refresh urgent, level; synchronous to `CLK`.
- `nAS` in 1: CPU address strobe, active low.
- `RAMCS` in 1: current CPU cycle targets RAM.
- `nRAS` out 1: refresh RAS strobe, active low.
- `nCAS` out 1: refresh CAS strobe, active low.
- `RAMHold` out 1: RAM controller must not start a new RAM access.
- `RefAck` out 1: one-cycle pulse when a refresh completes.
- `RefMiss` out 1: sticky flag, a refresh period elapsed unserviced (only with `REF_MISS_EN`).

## Operation

**Reset**
- While `nPOR`=0: state IDLE, `nRAS`=`nCAS`=1, `RAMHold`=0, `RefAck`=0, `RefMiss`=0, pending=0, counter=0.
- Reset is asynchronous and aborts any cycle in progress, including mid-RAS.

**Pending request**
- Set on a `RefReq` rising edge, detected against a one-cycle registered copy. The registered copy resets to 1, so there is no spurious request on the first cycle after reset.
- Cleared when the CBR cycle enters RASLO.

**Bus idle condition:** `Idle = nAS || !RAMCS`, evaluated combinationally each cycle.

**State machine** (all outputs registered):
- IDLE: go to PEND if pending.
- PEND:
  - `RAMHold` = `RefUrg`.
  - If `Idle`, go to CASLO and load counter = `TCASPRE`−1.
- CASLO:
  - `nCAS`=0, `RAMHold`=1.
  - At counter=0, go to RASLO with counter = `TRAS`−1; otherwise decrement.
- RASLO:
  - `nCAS`=0, `nRAS`=0, `RAMHold`=1.
  - At counter=0, go to PRECH with counter = `TRP`−1.
- PRECH:
  - Strobes high, `RAMHold`=1.
  - At counter=0, go to IDLE and pulse `RefAck` for 1 cycle.

**Boundary conditions**
- A `RefReq` rise during CASLO/RASLO/PRECH sets pending again. That request is serviced after returning to IDLE, with no loss.
- A `RefReq` rise while pending is still set (PEND, or IDLE with pending) is a miss and is counted (see Configuration). Pending stays 1 and only one refresh is owed.
- `RefUrg` deasserting while in PEND drops `RAMHold` the next cycle; the refresh stays pending.
- `RAMHold` never rises in the middle of a CPU RAM cycle when entering CASLO, because entry requires `Idle`.

## Timing
- The cycle sequence is a fixed-length tail once started.
- With an immediate start, `RefReq` rise at edge N gives:
  - pending=1 at N+1
  - PEND at N+2
  - `nCAS`↓ at N+3
  - `nRAS`↓ at N+3+`TCASPRE`
  - `nRAS`/`nCAS`↑ at N+3+`TCASPRE`+`TRAS`
  - `RefAck` at N+3+`TCASPRE`+`TRAS`+`TRP`
- Defaults: `nCAS` low for 4 cycles and `nRAS` low for 3 cycles; `RefAck` 6 cycles after `nCAS` falls.
- `RAMHold` in the urgent case: asserted the cycle after PEND is entered with `RefUrg`=1. Held continuously until IDLE is re-entered, and deasserted in the same cycle `RefAck` pulses.
- `nCAS` always falls at least `TCASPRE` cycles before `nRAS`, and both rise on the same edge (CBR-compliant).

## Configuration
- `REF_MISS_EN` defined:
  - A 4-bit saturating miss counter increments on each miss event and saturates at 15.
  - `RefMiss` = counter≠0.
  - The counter clears only on `nPOR`.
- `REF_MISS_EN` undefined: no counter is built, `RefMiss` is tied to 0, and misses are silently merged.

## Test plan
- **Idle bus:** `nAS`=1; pulse `RefReq` 0→1. `nCAS`↓ 3 cycles later; `nRAS` low for cycles 4–6; `RefAck` at cycle 9; `RAMHold` 1 for cycles 3–8.
- **Busy RAM:** `nAS`=0, `RAMCS`=1, `RefReq`↑ with `RefUrg`=0. Stays in PEND with `RAMHold`=0. Raise `RefUrg` → `RAMHold`=1 next cycle. Release `nAS` → `nCAS`↓ the following edge.
- **Non-RAM cycle:** `nAS`=0, `RAMCS`=0. Refresh starts without waiting.
- **Back-to-back:** `RefReq` re-rises during RASLO. A second complete CBR follows the first `RefAck`, and `RefMiss` stays 0.
- **Miss** (`REF_MISS_EN`): hold the bus busy across three `RefReq` rises. `RefMiss`=1 and counter=2; exactly one refresh is issued after release.
- **Reset mid-RASLO:** drop `nPOR`. `nRAS`=`nCAS`=1 and `RAMHold`=0 immediately, without waiting for a clock edge. After release, no refresh occurs until the next `RefReq` rise.
